// File: rtl/seq_multiplier_16.sv
// Iterative shift-add unsigned multiplier with a start/busy/done handshake.
// Each RUN cycle performs one WIDTH-bit add through chained 4-bit ripple adders.

module four_bit_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic c;

    // Bit-serial ripple through the nibble
    always_comb begin
        c = ci;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    end

endmodule

module seq_multiplier_16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               hi_nz,
    output logic               zero
);

    localparam int unsigned NIB = WIDTH / 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   acc_hi, acc_hi_nxt;
    logic [WIDTH-1:0]   mcand, mcand_nxt;
    logic [WIDTH-1:0]   mplier, mplier_nxt;
    logic [2*WIDTH-1:0] product_nxt;
    logic               hi_nz_nxt;
    logic               zero_nxt;
    logic               busy_nxt;
    logic               done_nxt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum_lo;
    logic [NIB:0]       carry;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] final_prod;

    assign addend   = mplier[0] ? mcand : '0;
    assign carry[0] = 1'b0;

    for (genvar g = 0; g < NIB; g++) begin : g_nib
        four_bit_adder u_add (
            .x  (acc_hi[4*g +: 4]),
            .y  (addend[4*g +: 4]),
            .ci (carry[g]),
            .s  (sum_lo[4*g +: 4]),
            .co (carry[g+1])
        );
    end

    // Carry-out is kept as the top bit so the shift never loses it
    assign sum        = {carry[NIB], sum_lo};
    assign final_prod = {sum, mplier[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            acc_hi  <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            hi_nz   <= 1'b0;
            zero    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            acc_hi  <= acc_hi_nxt;
            mcand   <= mcand_nxt;
            mplier  <= mplier_nxt;
            product <= product_nxt;
            hi_nz   <= hi_nz_nxt;
            zero    <= zero_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_hi_nxt  = acc_hi;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        product_nxt = product;
        hi_nz_nxt   = hi_nz;
        zero_nxt    = zero;
        busy_nxt    = busy;
        done_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    mcand_nxt  = a;
                    mplier_nxt = b;
                    acc_hi_nxt = '0;
                    cnt_nxt    = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                acc_hi_nxt = sum[WIDTH:1];
                mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
                cnt_nxt    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    product_nxt = final_prod;
                    hi_nz_nxt   = |final_prod[2*WIDTH-1:WIDTH];
                    zero_nxt    = ~|final_prod;
                    done_nxt    = 1'b1;
                    state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_multiplier_16.sv
// Directed-vector and sweep bench for seq_multiplier_16.

module tb_seq_multiplier_16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        hi_nz;
    logic        zero;

    int n_vec;
    int n_err;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic [31:0] ep;
        logic        ehi;
        logic        ez;
    } vec_t;

    seq_multiplier_16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .hi_nz   (hi_nz),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction: start edge, latency count, result checks
    task automatic run_mul(input logic [15:0] xa, input logic [15:0] xb,
                           input logic [31:0] ep, input logic ehi, input logic ez,
                           input string tag);
        int k;
        @(negedge clk);
        a = xa;
        b = xb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'd16);
        chk({tag, " product"}, product, ep);
        chk({tag, " hi_nz"}, 32'(hi_nz), 32'(ehi));
        chk({tag, " zero"}, 32'(zero), 32'(ez));
        @(posedge clk);
        #1;
        chk({tag, " done_single_pulse"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int pulses, dk1, dk2, k;
        logic [31:0] p1, p2, rp;
        logic        h2;
        logic [15:0] ra, rb;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h0000, 32'h00000000, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'hFFFF, 32'h00000000, 1'b0, 1'b1};
        vecs[4] = '{16'h0001, 16'hFFFF, 32'h0000FFFF, 1'b0, 1'b0};
        vecs[5] = '{16'h0100, 16'h0100, 32'h00010000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 32'h40000000, 1'b1, 1'b0};

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset product", product, 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset hi_nz", 32'(hi_nz), 32'd0);
        chk("reset zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_mul(vecs[i].va, vecs[i].vb, vecs[i].ep, vecs[i].ehi, vecs[i].ez, $sformatf("vec%0d", i));

        // start held high; operands disturbed during RUN
        @(negedge clk);
        a = 16'h00FF;
        b = 16'h0101;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'hAAAA;
        b = 16'hAAAA;
        pulses = 0;
        dk1 = -1;
        dk2 = -1;
        p1 = '0;
        p2 = '0;
        h2 = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (dk1 < 0) begin
                    dk1 = k;
                    p1 = product;
                end else if (dk2 < 0) begin
                    dk2 = k;
                    p2 = product;
                    h2 = hi_nz;
                end
            end
            if (k == 17) chk("hold idle_after_done", 32'(busy), 32'd0);
            if (k == 18) begin
                chk("hold restart_busy", 32'(busy), 32'd1);
                start = 1'b0;
            end
        end
        chk("hold first_done_edge", 32'(dk1), 32'd16);
        chk("hold first_product", p1, 32'h0000FFFF);
        chk("hold second_done_edge", 32'(dk2), 32'd34);
        chk("hold second_product", p2, 32'h71C638E4);
        chk("hold second_hi_nz", 32'(h2), 32'd1);
        chk("hold pulse_count", 32'(pulses), 32'd2);

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        a = 16'h8000;
        b = 16'h0002;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort product", product, 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("abort no_done", 32'(pulses), 32'd0);
        run_mul(16'h8000, 16'h0002, 32'h00010000, 1'b1, 1'b0, "post_abort");

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rp = 32'(ra) * 32'(rb);
            run_mul(ra, rb, rp, |rp[31:16], rp == 32'd0, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
